// File: rtl/hack_cpu_sequencer_pkg.sv
// Shared types for the Hack CPU control sequencer: state codes and IR field layout.
package hack_cpu_sequencer_pkg;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_IDLE     = 4'd1,
    S_FETCH    = 4'd2,
    S_DECODE   = 4'd3,
    S_MEMRD    = 4'd4,
    S_EXEC     = 4'd5,
    S_MEMWR    = 4'd6,
    S_COMMIT_A = 4'd7,
    S_COMMIT_C = 4'd8,
    S_FAULT    = 4'd9
  } state_e;

  // Bit positions inside a Hack instruction word.
  localparam int CBIT    = 15;
  localparam int ABIT    = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;
  localparam int JUMP_HI = 2;
  localparam int JUMP_LO = 0;

  // Only the fields the sequencer acts on are kept; IR[14:13] are don't-care bits.
  typedef struct packed {
    logic       cbit;
    logic       abit;
    logic [5:0] comp;
    logic       dest_a;
    logic       dest_d;
    logic       dest_m;
    logic [2:0] jump;
  } ir_t;

  // States in which the sequencer waits on a bus handshake and the timeout runs.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/hack_cpu_sequencer_if.sv
// Bus/control bundle between the sequencer (master) and the ROM/RAM/datapath (slave).
interface hack_cpu_sequencer_if;

  logic        run;
  logic [15:0] instr;
  logic        rom_ready;
  logic        mem_ready;
  logic        zr;
  logic        ng;

  logic        rom_req;
  logic        mem_rd;
  logic        mem_wr;
  logic        a_load;
  logic        a_sel_instr;
  logic        d_load;
  logic        am_sel;
  logic [5:0]  alu_ctl;
  logic        pc_reset;
  logic        pc_load;
  logic        pc_inc;
  logic        instr_done;
  logic        fault;
  logic [2:0]  state_dbg;

  modport master (
    input  run, instr, rom_ready, mem_ready, zr, ng,
    output rom_req, mem_rd, mem_wr, a_load, a_sel_instr, d_load, am_sel, alu_ctl,
           pc_reset, pc_load, pc_inc, instr_done, fault, state_dbg
  );

  modport slave (
    output run, instr, rom_ready, mem_ready, zr, ng,
    input  rom_req, mem_rd, mem_wr, a_load, a_sel_instr, d_load, am_sel, alu_ctl,
           pc_reset, pc_load, pc_inc, instr_done, fault, state_dbg
  );

endinterface

// File: rtl/hack_cpu_sequencer_jump_unit.sv
// Jump condition: j1 = out<0, j2 = out==0, j3 = out>0, evaluated on the ALU flags.
module hack_jump_unit (
  input  logic [2:0] jump,
  input  logic       zr,
  input  logic       ng,
  output logic       jmp
);

  assign jmp = (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~ng & ~zr);

endmodule

// File: rtl/hack_cpu_sequencer.sv
// Multi-cycle Hack CPU control FSM: fetch, decode, RAM read/write, commit to A/D/PC.
module hack_cpu_sequencer
  import hack_cpu_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  hack_cpu_sequencer_if.master bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_e           state_q, state_d;
  ir_t              ir_q;
  logic             reset_q;
  logic             jmp_q;
  logic             jmp_now;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             ready_now;
  logic             timed_out;
  logic             c_path;
  logic             unused_instr_bits;

  assign unused_instr_bits = ^bus.instr[14:13];

  hack_jump_unit u_jump (
    .jump (ir_q.jump),
    .zr   (bus.zr),
    .ng   (bus.ng),
    .jmp  (jmp_now)
  );

  // State, IR, latched jump decision and wait counter. reset_q holds RST silent
  // while reset is asserted so pc_reset fires exactly once after release.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= S_RST;
      reset_q <= 1'b1;
      // NOTE: IR and jmp are real control registers (not memories), so they are
      // cleared here to keep decoded outputs defined right after reset.
      ir_q    <= '0;
      jmp_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      reset_q <= 1'b0;
      wait_q  <= wait_d;
      if (state_q == S_FETCH && bus.rom_ready) begin
        ir_q <= {bus.instr[CBIT], bus.instr[ABIT], bus.instr[COMP_HI:COMP_LO],
                 bus.instr[DEST_A], bus.instr[DEST_D], bus.instr[DEST_M],
                 bus.instr[JUMP_HI:JUMP_LO]};
      end
      if (state_q == S_EXEC) begin
        jmp_q <= jmp_now;
      end
    end
  end

  // Next state, wait counter and Moore outputs decoded from state_q/ir_q only.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    state_d         = state_q;
    ready_now       = (state_q == S_FETCH) ? bus.rom_ready : bus.mem_ready;
    timed_out       = (TIMEOUT_CYCLES != 0) && !ready_now && (wait_q == CNT_LAST);
    wait_d          = (is_wait_state(state_q) && !ready_now) ? wait_q + 1'b1 : '0;
    c_path          = (state_q == S_MEMRD) || (state_q == S_EXEC) ||
                      (state_q == S_MEMWR) || (state_q == S_COMMIT_C);
    bus.rom_req     = 1'b0;
    bus.mem_rd      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.a_load      = 1'b0;
    bus.a_sel_instr = 1'b0;
    bus.d_load      = 1'b0;
    bus.am_sel      = c_path ? ir_q.abit : 1'b0;
    bus.alu_ctl     = c_path ? ir_q.comp : 6'd0;
    bus.pc_reset    = 1'b0;
    bus.pc_load     = 1'b0;
    bus.pc_inc      = 1'b0;
    bus.instr_done  = 1'b0;
    bus.fault       = 1'b0;
    bus.state_dbg   = state_q[2:0];

    unique case (state_q)
      S_RST: begin
        bus.pc_reset = ~reset_q;
        if (!reset_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        bus.rom_req = 1'b1;
        if (bus.rom_ready)  state_d = S_DECODE;
        else if (timed_out) state_d = S_FAULT;
      end
      S_DECODE: begin
        if (!ir_q.cbit)     state_d = S_COMMIT_A;
        else if (ir_q.abit) state_d = S_MEMRD;
        else                state_d = S_EXEC;
      end
      S_MEMRD: begin
        bus.mem_rd = 1'b1;
        if (bus.mem_ready)  state_d = S_EXEC;
        else if (timed_out) state_d = S_FAULT;
      end
      S_EXEC: begin
        state_d = ir_q.dest_m ? S_MEMWR : S_COMMIT_C;
      end
      S_MEMWR: begin
        bus.mem_wr = 1'b1;
        if (bus.mem_ready)  state_d = S_COMMIT_C;
        else if (timed_out) state_d = S_FAULT;
      end
      S_COMMIT_A: begin
        bus.a_load      = 1'b1;
        bus.a_sel_instr = 1'b1;
        bus.pc_inc      = 1'b1;
        bus.instr_done  = 1'b1;
        state_d         = bus.run ? S_FETCH : S_IDLE;
      end
      S_COMMIT_C: begin
        bus.a_load     = ir_q.dest_a;
        bus.d_load     = ir_q.dest_d;
        bus.pc_load    = jmp_q;
        bus.pc_inc     = ~jmp_q;
        bus.instr_done = 1'b1;
        state_d        = bus.run ? S_FETCH : S_IDLE;
      end
      S_FAULT: begin
        bus.fault = 1'b1;
      end
      default: begin
        state_d = S_RST;
      end
    endcase
  end

endmodule
